mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU in cycles (legal range 1-15).
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles (legal range 1-15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  EX-stage MD instruction valid; sampled on posedge clk.
REQ-006 SHALL have port op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved.
REQ-007 SHALL have port A  input  32  operand rs (forwarded value from EX stage).
REQ-008 SHALL have port B  input  32  operand rt (forwarded value from EX stage).
REQ-009 SHALL have port md_use_D  input  1  instruction in D stage is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port md_stall  output  1  stall request to hazard unit; deasserts IF/ID and ID/EX enable and flushes ID/EX.
REQ-012 SHALL have port HI  output  32  HI register.
REQ-013 SHALL have port LO  output  32  LO register.

Function
REQ-014 SHALL accept an operation only on a posedge where start=1, busy=0 and reset=0; start with busy=1 SHALL be ignored, with no state change.
REQ-015 SHALL, on accepting op 0-3, capture A and B into internal registers, load the cycle counter with MULT_CYCLES (ops 0-1) or DIV_CYCLES (ops 2-3), and assert busy from the next cycle.
REQ-016 SHALL keep busy=1 for exactly N consecutive cycles after the accepting edge (N = loaded count), decrementing the counter once per edge.
REQ-017 SHALL write HI/LO on the edge where the counter goes 1->0; busy SHALL be 0 in the cycle after that edge.
REQ-018 SHALL compute results only from captured operands; changes on A/B while busy SHALL NOT affect the result.
REQ-019 MULT SHALL form the signed 64-bit product {HI,LO} = $signed(A)*$signed(B); MULTU SHALL form the unsigned 64-bit product.
REQ-020 DIV SHALL give signed quotient to LO (truncated toward zero) and remainder to HI (sign of dividend); DIVU SHALL give the unsigned quotient and remainder.
REQ-021 DIV with A=0x80000000 and B=0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-022 DIV or DIVU with B=0 SHALL complete with the normal DIV_CYCLES busy period and leave HI/LO unchanged.
REQ-023 MTHI/MTLO SHALL write A to HI/LO on the accepting edge, with no busy period; the written value SHALL be visible in the next cycle.
REQ-024 Reserved op codes 6-7 with start=1 SHALL be ignored.
REQ-025 md_stall SHALL be combinational: md_stall = md_use_D & (busy | (start & op<=3)).
REQ-026 While busy=0 and start=0, HI/LO SHALL hold their values indefinitely.

Reset
REQ-027 On a posedge with reset=1, the block SHALL set busy=0, the counter to 0, HI=0x00000000, LO=0x00000000, and discard any in-flight operation regardless of its progress.
REQ-028 reset SHALL take priority over start on the same edge; the operation SHALL NOT be accepted.
REQ-029 After reset deasserts, the block SHALL accept start on the first edge with reset=0.

Verification
REQ-030 The bench SHALL cover: MULT A=0xFFFFFFFE (-2), B=3 -> busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 The bench SHALL cover: DIV A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 -> LO=3, HI=1.
REQ-032 The bench SHALL cover: DIV with B=0 after HI=0x11, LO=0x22 -> busy for 10 cycles, then HI=0x11, LO=0x22; also DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 The bench SHALL cover: start MULT, then on cycle 2 of busy assert start with op=MTHI, A=0x55 and change A/B -> MTHI ignored, MULT result uses the original operands.
REQ-034 The bench SHALL cover: md_use_D=1 during busy -> md_stall=1 every busy cycle, 0 the cycle busy falls; md_use_D=0 during busy -> md_stall=0.
REQ-035 The bench SHALL cover: reset asserted on busy cycle 3 of a DIV -> next cycle busy=0, HI=LO=0, no late write-back; start together with reset -> not accepted.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle HI/LO multiply/divide unit for a classic five-stage pipeline.
//   MULT/MULTU hold busy for MULT_CYCLES cycles and DIV/DIVU for DIV_CYCLES
//   cycles. The result is written to {HI,LO} on the edge where the countdown
//   reaches zero. MTHI/MTLO write HI/LO directly, with no busy period.
//
// Ports
//   clk       single clock; all state changes on posedge
//   reset     synchronous, active-high; clears busy, counter, HI and LO
//   start     MD instruction valid in EX
//   op        0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7 ignored
//   A, B      rs / rt operands (forwarded EX values)
//   md_use_D  instruction in D stage touches the MD unit
//   busy      multi-cycle operation in progress
//   md_stall  combinational stall request to the hazard unit
//   HI, LO    architectural HI/LO registers
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    // Full 64-bit product. A sign- or zero-extended 64x64 product truncated
    // to 64 bits equals the exact signed or unsigned 32x32 product.
    function automatic logic signed [63:0] mul64(input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input logic        sgn);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = sgn ? $signed({{32{a[31]}}, a}) : $signed({32'd0, a});
        eb = sgn ? $signed({{32{b[31]}}, b}) : $signed({32'd0, b});
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. The signed case is computed on
    // magnitudes, so 0x80000000 / -1 falls out as quotient 0x80000000 and
    // remainder 0 instead of hitting a signed overflow. Divide by zero
    // returns zeros, and the caller suppresses the write-back.
    function automatic logic [63:0] div64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic        na;
        logic        nb;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        na = sgn & a[31];
        nb = sgn & b[31];
        ma = na ? (~a + 32'd1) : a;
        mb = nb ? (~b + 32'd1) : b;
        if (mb == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (na ^ nb) q = ~q + 32'd1;
        if (na)      r = ~r + 32'd1;
        return {r, q};
    endfunction

    logic [3:0]         cnt;
    logic               busy_q;
    logic [1:0]         op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic signed [63:0] prod;
    logic [63:0]        divres;
    logic               capture;

    // Operands are captured only when a multi-cycle op is accepted. After
    // that, A/B can change freely without affecting the pending result.
    assign capture = start & ~busy_q & ~op[2];

    always_comb begin
        prod   = mul64(a_q, b_q, ~op_q[0]);
        divres = div64(a_q, b_q, ~op_q[0]);
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            op_q <= op[1:0];
            a_q  <= A;
            b_q  <= B;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt    <= 4'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else if (busy_q) begin
            // Count down. Write back on the 1->0 step.
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                busy_q <= 1'b0;
                if (op_q[1]) begin
                    if (b_q != 32'd0) begin
                        hi_q <= divres[63:32];
                        lo_q <= divres[31:0];
                    end
                end else begin
                    hi_q <= prod[63:32];
                    lo_q <= prod[31:0];
                end
            end
        end else if (start) begin
            case (op)
                3'd0, 3'd1: begin
                    busy_q <= 1'b1;
                    cnt    <= MULT_CNT;
                end
                3'd2, 3'd3: begin
                    busy_q <= 1'b1;
                    cnt    <= DIV_CNT;
                end
                3'd4:    hi_q <= A;
                3'd5:    lo_q <= A;
                default: ;
            endcase
        end
    end

    assign busy     = busy_q;
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign md_stall = md_use_D & (busy_q | (start & (op <= 3'd3)));

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed bench for mult_div_unit. Inputs change and outputs are sampled
//   on the falling clock edge. The DUT registers on the rising edge.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        md_use_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .md_use_D (md_use_D),
        .busy     (busy),
        .md_stall (md_stall),
        .HI       (HI),
        .LO       (LO)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for a single rising edge. Returns at the next falling
    // edge, which is busy cycle 1 for a multi-cycle op.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count the falling edges that see busy high, bounded at 40.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'd0;
        A        = 32'd0;
        B        = 32'd0;
        md_use_D = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy",  {31'd0, busy},     32'd0);
        check("reset_hi",    HI,                32'd0);
        check("reset_lo",    LO,                32'd0);
        check("reset_stall", {31'd0, md_stall}, 32'd0);
        reset = 1'b0;

        // MULT -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_done(n);
        check("mult_cycles", n,  32'd5);
        check("mult_hi",     HI, 32'hFFFF_FFFF);
        check("mult_lo",     LO, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFE * 3
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_done(n);
        check("multu_cycles", n,  32'd5);
        check("multu_hi",     HI, 32'h0000_0002);
        check("multu_lo",     LO, 32'hFFFF_FFFA);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        check("div_cycles", n,  32'd10);
        check("div_lo",     LO, 32'hFFFF_FFFD);
        check("div_hi",     HI, 32'hFFFF_FFFF);

        // DIVU 7 / 2
        issue(3'd3, 32'd7, 32'd2);
        wait_done(n);
        check("divu_cycles", n,  32'd10);
        check("divu_lo",     LO, 32'd3);
        check("divu_hi",     HI, 32'd1);

        // MTHI / MTLO: no busy, value visible in the next cycle
        issue(3'd4, 32'h11, 32'h0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi",   HI,            32'h11);
        issue(3'd5, 32'h22, 32'h0);
        check("mtlo_lo",   LO,            32'h22);
        check("mtlo_hi",   HI,            32'h11);

        // Divide by zero leaves HI/LO unchanged
        issue(3'd2, 32'd5, 32'd0);
        wait_done(n);
        check("div0_cycles", n,  32'd10);
        check("div0_hi",     HI, 32'h11);
        check("div0_lo",     LO, 32'h22);

        // DIV overflow case
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        check("divovf_lo", LO, 32'h8000_0000);
        check("divovf_hi", HI, 32'h0000_0000);

        // Reserved op: ignored, no stall request
        md_use_D = 1'b1;
        start = 1'b1; op = 3'd6; A = 32'hDEAD_BEEF; B = 32'h1;
        #1;
        check("resv_stall", {31'd0, md_stall}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("resv_busy", {31'd0, busy}, 32'd0);
        check("resv_hi",   HI,            32'h0);
        check("resv_lo",   LO,            32'h8000_0000);
        md_use_D = 1'b0;

        // MTHI while busy is ignored; operands are frozen at accept
        issue(3'd0, 32'h1000, 32'h10);
        @(negedge clk);                      // busy cycle 2
        issue(3'd4, 32'h55, 32'h99);         // now at busy cycle 3
        A = 32'h1234_5678;
        B = 32'h7777_7777;
        wait_done(n);
        check("iso_cycles", n,  32'd3);
        check("iso_hi",     HI, 32'h0);
        check("iso_lo",     LO, 32'h0001_0000);

        // Hold while idle
        repeat (3) @(negedge clk);
        check("hold_hi", HI, 32'h0);
        check("hold_lo", LO, 32'h0001_0000);

        // md_stall with md_use_D=1: issue cycle, every busy cycle, then low
        md_use_D = 1'b1;
        start = 1'b1; op = 3'd0; A = 32'd2; B = 32'd2;
        #1;
        check("stall_issue", {31'd0, md_stall}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_busy", {30'd0, busy, md_stall}, 32'd3);
            @(negedge clk);
        end
        check("stall_fall", {30'd0, busy, md_stall}, 32'd0);
        check("stall_lo",   LO, 32'd4);

        // md_use_D=0: no stall during busy
        md_use_D = 1'b0;
        issue(3'd1, 32'd3, 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("nostall_busy", {30'd0, busy, md_stall}, 32'd2);
            @(negedge clk);
        end
        check("nostall_lo", LO, 32'd9);

        // Reset on busy cycle 3 of a DIV discards the op
        issue(3'd4, 32'hAA, 32'h0);
        issue(3'd2, 32'd100, 32'd7);         // busy cycle 1
        @(negedge clk);                      // busy cycle 2
        @(negedge clk);                      // busy cycle 3
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi",   HI,            32'h0);
        check("rst_mid_lo",   LO,            32'h0);
        repeat (12) @(negedge clk);
        check("rst_late_hi",   HI,            32'h0);
        check("rst_late_lo",   LO,            32'h0);
        check("rst_late_busy", {31'd0, busy}, 32'd0);

        // start together with reset is not accepted
        reset = 1'b1;
        start = 1'b1; op = 3'd4; A = 32'h77; B = 32'h0;
        @(negedge clk);
        op = 3'd0; A = 32'd3; B = 32'd3;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        check("rst_start_hi",   HI,            32'h0);

        // The first edge after reset accepts
        issue(3'd0, 32'd6, 32'd7);
        check("post_rst_busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("post_rst_cycles", n,  32'd5);
        check("post_rst_lo",     LO, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
